// File: rtl/stoch_mult_param.sv
// Stochastic multiplier: two LFSR/comparator bitstreams, AND (unipolar) or XNOR (bipolar), ones counted over 2^WIN_LOG2 bits.
// done pulses 2^WIN_LOG2+2 cycles after an accepted start; start is ignored while busy, so no backpressure is applied upstream.
module stoch_mult_param #(
  parameter int                PW       = 8,
  parameter int                LFSR_W   = 31,
  parameter int                WIN_LOG2 = 8,
  parameter logic [LFSR_W-1:0] SEED_A   = 31'd1,
  parameter logic [LFSR_W-1:0] SEED_B   = 31'd2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                mode,
  input  logic [PW-1:0]       prob_a,
  input  logic [PW-1:0]       prob_b,
  output logic                busy,
  output logic                done,
  output logic [WIN_LOG2:0]   result,
  output logic                sn_out
);

  localparam logic [LFSR_W-1:0] SEED_A_EFF = (SEED_A == '0) ? LFSR_W'(1) : SEED_A;
  localparam logic [LFSR_W-1:0] SEED_B_EFF = (SEED_B == '0) ? LFSR_W'(1) : SEED_B;
  // A is x^31+x^28+1; B uses the reciprocal polynomial so the two streams decorrelate.
  localparam int TAP_A = LFSR_W - 4;
  localparam int TAP_B = 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 w_accept;
  logic                 w_step;
  logic                 w_last;

  logic [LFSR_W-1:0]    r_lfsr_a;
  logic [LFSR_W-1:0]    r_lfsr_b;
  logic [PW-1:0]        r_prob_a;
  logic [PW-1:0]        r_prob_b;
  logic                 r_mode;
  logic                 r_sn;
  logic [WIN_LOG2:0]    r_cnt;
  logic [WIN_LOG2-1:0]  r_idx;
  logic [WIN_LOG2:0]    r_result;

  logic [PW-1:0]        w_rand_a;
  logic [PW-1:0]        w_rand_b;
  logic                 w_sn_a;
  logic                 w_sn_b;
  logic                 w_sn_comb;
  logic [WIN_LOG2-1:0]  w_idx_inc;
  logic [WIN_LOG2:0]    w_cnt_inc;

  assign w_rand_a  = r_lfsr_a[LFSR_W-1 -: PW];
  assign w_rand_b  = r_lfsr_b[LFSR_W-1 -: PW];
  assign w_sn_a    = (w_rand_a < r_prob_a);
  assign w_sn_b    = (w_rand_b < r_prob_b);
  assign w_sn_comb = r_mode ? ~(w_sn_a ^ w_sn_b) : (w_sn_a & w_sn_b);
  assign w_idx_inc = r_idx + WIN_LOG2'(1);
  assign w_cnt_inc = r_cnt + (WIN_LOG2+1)'(r_sn);

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_step      = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = S_FILL;
        end
      end
      S_FILL: begin
        w_step      = 1'b1;
        w_state_nxt = S_RUN;
      end
      S_RUN: begin
        w_step = 1'b1;
        // Index wrapping back to zero marks the final window bit.
        if (w_idx_inc == '0) begin
          w_last      = 1'b1;
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_lfsr_a <= SEED_A_EFF;
      r_lfsr_b <= SEED_B_EFF;
      r_prob_a <= '0;
      r_prob_b <= '0;
      r_mode   <= 1'b0;
      r_sn     <= 1'b0;
    end else if (w_accept) begin
      r_lfsr_a <= SEED_A_EFF;
      r_lfsr_b <= SEED_B_EFF;
      r_prob_a <= prob_a;
      r_prob_b <= prob_b;
      r_mode   <= mode;
    end else if (w_step) begin
      r_lfsr_a <= {r_lfsr_a[LFSR_W-2:0], r_lfsr_a[LFSR_W-1] ^ r_lfsr_a[TAP_A]};
      r_lfsr_b <= {r_lfsr_b[LFSR_W-2:0], r_lfsr_b[LFSR_W-1] ^ r_lfsr_b[TAP_B]};
      r_sn     <= w_sn_comb;
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_cnt    <= '0;
      r_idx    <= '0;
      r_result <= '0;
    end else begin
      if (w_accept) begin
        r_cnt <= '0;
        r_idx <= '0;
      end else if (r_state == S_RUN) begin
        r_cnt <= w_cnt_inc;
        r_idx <= w_idx_inc;
      end
      if (w_last) begin
        r_result <= w_cnt_inc;
      end
    end
  end

  assign busy   = (r_state != S_IDLE);
  assign done   = (r_state == S_DONE);
  assign result = r_result;
  assign sn_out = r_sn;

endmodule

// File: tb/tb_stoch_mult_param.sv
// Bench for stoch_mult_param: window-level reference model checked every cycle, plus directed literal expectations.
module tb_stoch_mult_param;

  localparam int PW  = 8;
  localparam int LW  = 31;
  localparam int WL  = 8;
  localparam int N   = 1 << WL;
  localparam logic [LW-1:0] SA = 31'd1;
  localparam logic [LW-1:0] SB = 31'd2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          mode;
  logic [PW-1:0] prob_a;
  logic [PW-1:0] prob_b;
  logic          busy;
  logic          done;
  logic [WL:0]   result;
  logic          sn_out;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  stoch_mult_param #(
    .PW(PW), .LFSR_W(LW), .WIN_LOG2(WL), .SEED_A(SA), .SEED_B(SB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
    .prob_a(prob_a), .prob_b(prob_b),
    .busy(busy), .done(done), .result(result), .sn_out(sn_out)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference stream: combined bit for LFSR states 0..N after seeding.
  bit m_seq [N+1];

  function automatic void build_stream(input logic [PW-1:0] pa, input logic [PW-1:0] pb, input logic md);
    logic [LW-1:0] a;
    logic [LW-1:0] b;
    logic sa;
    logic sb;
    a = (SA == '0) ? LW'(1) : SA;
    b = (SB == '0) ? LW'(1) : SB;
    for (int j = 0; j <= N; j++) begin
      sa = (a[LW-1 -: PW] < pa);
      sb = (b[LW-1 -: PW] < pb);
      m_seq[j] = md ? (sa == sb) : (sa && sb);
      a = {a[LW-2:0], a[30] ^ a[27]};
      b = {b[LW-2:0], b[30] ^ b[2]};
    end
  endfunction

  function automatic int window_sum();
    int s;
    s = 0;
    for (int j = 0; j < N; j++) s += int'(m_seq[j]);
    return s;
  endfunction

  function automatic int count_b_all_ones();
    logic [LW-1:0] b;
    int s;
    b = (SB == '0) ? LW'(1) : SB;
    s = 0;
    for (int j = 0; j < N; j++) begin
      if (b[LW-1 -: PW] == {PW{1'b1}}) s++;
      b = {b[LW-2:0], b[30] ^ b[2]};
    end
    return s;
  endfunction

  // Model: k = cycles since the accepted start (0 = idle); DONE is cycle N+2.
  int          k = 0;
  int          pend = 0;
  logic        e_sn = 1'b0;
  logic [WL:0] e_res = '0;

  always @(posedge clk) begin
    if (rst_n) begin
      k     = 0;
      e_res = '0;
      e_sn  = 1'b0;
    end else if (k == 0) begin
      if (start) begin
        build_stream(prob_a, prob_b, mode);
        pend = window_sum();
        k    = 1;
      end
    end else begin
      k++;
      if (k == N + 3) k = 0;
    end
    if (k >= 2) e_sn = m_seq[k-2];
    if (k == N + 2) e_res = (WL+1)'(pend);
    #1;
    chk("cyc_busy",   32'(busy),   32'(k != 0));
    chk("cyc_done",   32'(done),   32'(k == N + 2));
    chk("cyc_result", 32'(result), 32'(e_res));
    chk("cyc_sn_out", 32'(sn_out), 32'(e_sn));
  end

  task automatic run_op(input logic md, input logic [PW-1:0] pa, input logic [PW-1:0] pb,
                        input int lit, input bit scramble);
    int n;
    bit seen;
    @(negedge clk);
    start  = 1'b1;
    mode   = md;
    prob_a = pa;
    prob_b = pb;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    chk("op_busy_c1", 32'(busy), 32'd1);
    seen = 1'b0;
    while (!seen && n < 400) begin
      if (done) begin
        seen = 1'b1;
      end else begin
        if (scramble) begin
          start  = 1'($urandom);
          mode   = 1'($urandom);
          prob_a = PW'($urandom);
          prob_b = PW'($urandom);
        end
        @(negedge clk);
        n++;
      end
    end
    start = 1'b0;
    chk("op_done_cycle", 32'(n), 32'(N + 2));
    if (lit >= 0) chk("op_result_lit", 32'(result), 32'(lit));
    @(negedge clk);
    chk("op_done_pulse", 32'(done), 32'd0);
    chk("op_idle_after", 32'(busy), 32'd0);
  endtask

  initial begin
    #500000;
    bad++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    int n;
    int ndone;
    int last;
    int exp_b;

    rst_n  = 1'b1;
    start  = 1'b0;
    mode   = 1'b0;
    prob_a = '0;
    prob_b = '0;

    // Reset held with random inputs and start toggling.
    repeat (6) begin
      @(negedge clk);
      start  = 1'($urandom);
      mode   = 1'($urandom);
      prob_a = PW'($urandom);
      prob_b = PW'($urandom);
    end
    @(negedge clk);
    chk("rst_busy",   32'(busy),   32'd0);
    chk("rst_done",   32'(done),   32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_sn_out", 32'(sn_out), 32'd0);
    start = 1'b0;
    rst_n = 1'b0;

    // Product of zero with unipolar AND is zero; bipolar 0*0 -> every bit XNORs to 1.
    run_op(1'b0, 8'h00, 8'hFF, 0, 1'b0);
    run_op(1'b1, 8'h00, 8'h00, N, 1'b0);

    // Half/half in both modes, repeated to show reseeding.
    run_op(1'b0, 8'h80, 8'h80, -1, 1'b0);
    run_op(1'b1, 8'h80, 8'h80, -1, 1'b0);
    run_op(1'b1, 8'h80, 8'h80, -1, 1'b0);
    run_op(1'b0, 8'hFF, 8'hFF, -1, 1'b0);

    // Only rand_b == all-ones contributes; operand changes while busy must not matter.
    exp_b = count_b_all_ones();
    run_op(1'b1, 8'h00, 8'hFF, exp_b, 1'b0);
    run_op(1'b1, 8'h00, 8'hFF, exp_b, 1'b1);

    for (int i = 0; i < 6; i++) begin
      run_op(1'($urandom), PW'($urandom), PW'($urandom), -1, 1'($urandom));
    end

    // start held high: one operation per N+3 cycles.
    @(negedge clk);
    start  = 1'b1;
    mode   = 1'b1;
    prob_a = PW'($urandom);
    prob_b = PW'($urandom);
    ndone = 0;
    last  = -1;
    n     = 0;
    while (ndone < 3 && n < 1200) begin
      @(negedge clk);
      n++;
      if (done) begin
        if (last >= 0) chk("hold_spacing", 32'(n - last), 32'(N + 3));
        last = n;
        ndone++;
      end
    end
    chk("hold_ops", 32'(ndone), 32'd3);

    // Land in RUN cycle 100 of the next operation, then reset mid-flight.
    repeat (103) @(negedge clk);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    rst_n = 1'b1;
    start = 1'b0;
    #1;
    chk("midrst_busy",   32'(busy),   32'd0);
    chk("midrst_done",   32'(done),   32'd0);
    chk("midrst_result", 32'(result), 32'd0);
    chk("midrst_sn_out", 32'(sn_out), 32'd0);
    @(negedge clk);
    rst_n = 1'b0;
    run_op(1'b1, 8'h00, 8'h00, N, 1'b0);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stoch_mult_param.md
Name: stoch_mult_param

Overview:
Parametrised stochastic-computing multiplier. Two LFSR-driven comparators convert PW-bit binary probabilities into stochastic bitstreams. The streams are combined by AND (unipolar) or XNOR (bipolar). The ones are counted over a window of 2^WIN_LOG2 bits and the count is returned as a binary result with a start/done handshake. It sits in the stochastic test datapath between the ui_in operand pins and the uo_out result pins.

Parameters:
PW, 8, probability/operand width in bits; 1 <= PW <= LFSR_W.
LFSR_W, 31, LFSR length; fixed 31 in this generation, kept as a parameter for tap-table extension.
WIN_LOG2, 8, log2 of window length; 2 <= WIN_LOG2 <= 12.
SEED_A, 31'd1, LFSR A seed; a zero value is replaced by 1.
SEED_B, 31'd2, LFSR B seed; a zero value is replaced by 1.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous reset, active-high (asserted when 1, despite the name)
start  in  1  request; accepted only in IDLE
mode  in  1  0 = unipolar AND, 1 = bipolar XNOR; sampled on start
prob_a  in  PW  operand A probability; sampled on start
prob_b  in  PW  operand B probability; sampled on start
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle pulse, high in the DONE state
result  out  WIN_LOG2+1  ones count of the last completed window
sn_out  out  1  registered combined stochastic bit, for observation

Behaviour:
- Reset (async, rst_n=1):
  - state=IDLE; busy=0, done=0, result=0, sn_out=0.
  - Counter=0; LFSR A=SEED_A, LFSR B=SEED_B.
  - Captured operands and mode = 0.
- LFSR A: Fibonacci; shift left; new bit0 = q[30]^q[27] (x^31+x^28+1).
- LFSR B: new bit0 = q[30]^q[2] (reciprocal polynomial).
- Both LFSRs advance one step per cycle only in FILL and RUN. They hold in IDLE and DONE.
- Random words: rand_a = LFSR_A[LFSR_W-1 -: PW], rand_b likewise from LFSR B.
- Comparators (combinational):
  - sn_a = (rand_a < prob_a_q) and sn_b = (rand_b < prob_b_q), unsigned.
  - prob=0 gives sn=0 always.
  - prob=all-ones gives sn=0 only when rand=all-ones.
- Combine: sn_out <= mode_q ? ~(sn_a^sn_b) : (sn_a & sn_b). Registered every FILL/RUN cycle; holds otherwise.
- FSM:
  - IDLE: on start=1, capture prob_a/prob_b/mode, reload both LFSRs with their seeds, clear counter, go to FILL.
  - FILL (1 cycle): pipeline prime; counter not updated.
  - RUN (exactly 2^WIN_LOG2 cycles): counter += sn_out each cycle. An internal cycle index of WIN_LOG2 bits wraps to 0 to mark the end. On the last RUN cycle, result <= counter + sn_out, then go to DONE.
  - DONE (1 cycle): done=1, then go to IDLE.
- Latency: if start is accepted in cycle 0, done is high in cycle 2^WIN_LOG2+2. The next start can be accepted in cycle 2^WIN_LOG2+3.
- The window samples LFSR states 0 .. 2^WIN_LOG2-1 after seeding. Result is therefore a pure function of (prob_a, prob_b, mode, seeds, params).
- Width rule: result spans 0..2^WIN_LOG2 inclusive. No overflow or wrap is possible.
- Start while busy, including in the DONE cycle: ignored; no effect on the current operation.
- prob_a/prob_b/mode changes while busy: ignored, because the captured copies are used.
- result holds its value until the next DONE; it is updated only on the RUN→DONE transition.
- Reset mid-operation: immediate return to the reset values. A later start behaves identically to a start after power-up.

Test Plan:
1. Assert rst_n=1 with random inputs and clk running -> busy=0, done=0, result=0, sn_out=0; start is ignored while reset is held.
2. mode=0, prob_a=0x00, prob_b=0xFF, start pulse at cycle 0 -> done high only at cycle 258, result=0, busy high cycles 1..258.
3. mode=1, prob_a=0x00, prob_b=0x00 -> result=256 (full-scale, all-XNOR ones), done at cycle 258.
4. mode=0, prob_a=0x80, prob_b=0x80, then mode=1 with the same operands -> result bit-exact against the golden LFSR/comparator model. Repeat the same operation twice -> identical result (reseed check).
5. mode=1, prob_a=0x00, prob_b=0xFF -> result equals the model count of rand_b==0xFF over the window. Change prob_a to 0xFF mid-RUN -> result unchanged.
6. start held high continuously -> exactly one operation per 259 cycles, no start accepted while busy. Reset asserted at cycle 100 of RUN -> busy/done/result drop to 0 immediately; a fresh operation then matches scenario 3.
